// File: rtl/stopwatch_pkg.sv
// Shared stopwatch types: FSM state encoding, BCD digit limits and the mm:ss.cc time record.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } sw_state_e;

  localparam logic [3:0] DEC_MAX = 4'd9;
  localparam logic [3:0] SEX_MAX = 4'd5;

  typedef struct packed {
    logic [3:0] min_t;
    logic [3:0] min_o;
    logic [3:0] sec_t;
    logic [3:0] sec_o;
    logic [3:0] cs_t;
    logic [3:0] cs_o;
  } bcd_time_t;

  localparam bcd_time_t TIME_MAX = '{min_t: SEX_MAX, min_o: DEC_MAX,
                                     sec_t: SEX_MAX, sec_o: DEC_MAX,
                                     cs_t:  DEC_MAX, cs_o:  DEC_MAX};

endpackage

// File: rtl/stopwatch_core_if.sv
// Key-pulse inputs and display/status outputs of the stopwatch core.
// master = key/display side, slave = stopwatch_core.
interface stopwatch_core_if;
  logic       start_stop_p;
  logic       clear_p;
  logic       lap_p;
  logic       running;
  logic       lap_shown;
  logic [3:0] min_t;
  logic [3:0] min_o;
  logic [3:0] sec_t;
  logic [3:0] sec_o;
  logic [3:0] cs_t;
  logic [3:0] cs_o;

  modport master (
    output start_stop_p, clear_p, lap_p,
    input  running, lap_shown, min_t, min_o, sec_t, sec_o, cs_t, cs_o
  );

  modport slave (
    input  start_stop_p, clear_p, lap_p,
    output running, lap_shown, min_t, min_o, sec_t, sec_o, cs_t, cs_o
  );
endinterface

// File: rtl/stopwatch_core_bcd_digit.sv
// One BCD digit wrapping at `limit`; carry is combinational so a whole chain ripples in one cycle.
// Digit updates on the edge after inc; clr and reset zero it.
module bcd_digit (
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       inc,
  input  logic [3:0] limit,
  output logic [3:0] digit,
  output logic       carry
);
  logic [3:0] r_digit;

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      r_digit <= 4'd0;
    end else if (inc) begin
      r_digit <= (r_digit == limit) ? 4'd0 : r_digit + 4'd1;
    end
  end

  assign digit = r_digit;
  assign carry = inc && (r_digit == limit);
endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch FSM + centisecond prescaler + mm:ss.cc BCD counter with lap freeze; status follows a command one edge later,
// digits are registered one edge behind their source. STOPWATCH_SAT_EN: hold and pause at 59:59.99 instead of wrapping.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV = 1000000,
  parameter int CNT_W    = 32
) (
  input  logic            clk,
  input  logic            reset,
  stopwatch_core_if.slave sw
);
  sw_state_e        r_state;
  sw_state_e        w_state_nxt;
  logic [CNT_W-1:0] r_presc;
  bcd_time_t        w_live;
  bcd_time_t        r_lap;
  bcd_time_t        r_disp;
  logic             w_run;
  logic             w_tick;
  logic             w_inc;
  logic             w_sat_hit;
  logic             w_sat_blk;
  logic             w_clr_cnt;
  logic             w_lap_cap;
  logic [4:0]       w_carry;
  logic             w_carry_unused;
  logic [3:0]       w_min_t, w_min_o, w_sec_t, w_sec_o, w_cs_t, w_cs_o;

  assign w_run     = (r_state == RUN) || (r_state == LAP);
  assign w_tick    = w_run && (r_presc == CNT_W'(TICK_DIV - 1));
  assign w_clr_cnt = (r_state == PAUSE) && sw.clear_p;

`ifdef STOPWATCH_SAT_EN
  logic r_sat;

  assign w_sat_hit = w_tick && (w_live == TIME_MAX);
  assign w_sat_blk = r_sat;

  always_ff @(posedge clk) begin
    if (reset || w_clr_cnt) begin
      r_sat <= 1'b0;
    end else if (w_sat_hit) begin
      r_sat <= 1'b1;
    end
  end
`else
  assign w_sat_hit = 1'b0;
  assign w_sat_blk = 1'b0;
`endif

  assign w_inc = w_tick && !w_sat_hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // clear outranks start_stop, which outranks lap; only the winning pulse acts.
  always_comb begin
    w_state_nxt = r_state;
    w_lap_cap   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!sw.clear_p && sw.start_stop_p) w_state_nxt = RUN;
      end
      RUN: begin
        if (!sw.clear_p) begin
          if (sw.start_stop_p) begin
            w_state_nxt = PAUSE;
          end else if (sw.lap_p) begin
            w_state_nxt = LAP;
            w_lap_cap   = 1'b1;
          end
        end
      end
      LAP: begin
        if (sw.clear_p) begin
          w_state_nxt = RUN;
        end else if (sw.start_stop_p) begin
          w_state_nxt = PAUSE;
        end else if (sw.lap_p) begin
          w_lap_cap = 1'b1;
        end
      end
      PAUSE: begin
        if (sw.clear_p) begin
          w_state_nxt = IDLE;
        end else if (sw.start_stop_p && !w_sat_blk) begin
          w_state_nxt = RUN;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (w_sat_hit) w_state_nxt = PAUSE;
  end

  // Frozen in PAUSE so a resumed run finishes its partial tick.
  always_ff @(posedge clk) begin
    if (reset || w_clr_cnt || w_tick) begin
      r_presc <= '0;
    end else if (w_run) begin
      r_presc <= r_presc + CNT_W'(1);
    end else if (r_state == IDLE) begin
      r_presc <= '0;
    end
  end

  bcd_digit u_cs_o  (.clk(clk), .reset(reset), .clr(w_clr_cnt), .inc(w_inc),
                     .limit(DEC_MAX), .digit(w_cs_o),  .carry(w_carry[0]));
  bcd_digit u_cs_t  (.clk(clk), .reset(reset), .clr(w_clr_cnt), .inc(w_carry[0]),
                     .limit(DEC_MAX), .digit(w_cs_t),  .carry(w_carry[1]));
  bcd_digit u_sec_o (.clk(clk), .reset(reset), .clr(w_clr_cnt), .inc(w_carry[1]),
                     .limit(DEC_MAX), .digit(w_sec_o), .carry(w_carry[2]));
  bcd_digit u_sec_t (.clk(clk), .reset(reset), .clr(w_clr_cnt), .inc(w_carry[2]),
                     .limit(SEX_MAX), .digit(w_sec_t), .carry(w_carry[3]));
  bcd_digit u_min_o (.clk(clk), .reset(reset), .clr(w_clr_cnt), .inc(w_carry[3]),
                     .limit(DEC_MAX), .digit(w_min_o), .carry(w_carry[4]));
  bcd_digit u_min_t (.clk(clk), .reset(reset), .clr(w_clr_cnt), .inc(w_carry[4]),
                     .limit(SEX_MAX), .digit(w_min_t), .carry(w_carry_unused));

  assign w_live = {w_min_t, w_min_o, w_sec_t, w_sec_o, w_cs_t, w_cs_o};

  always_ff @(posedge clk) begin
    if (reset || w_clr_cnt) begin
      r_lap <= '0;
    end else if (w_lap_cap) begin
      r_lap <= w_live;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_disp <= '0;
    end else begin
      r_disp <= (r_state == LAP) ? r_lap : w_live;
    end
  end

  assign sw.running   = w_run;
  assign sw.lap_shown = (r_state == LAP);
  assign sw.min_t     = r_disp.min_t;
  assign sw.min_o     = r_disp.min_o;
  assign sw.sec_t     = r_disp.sec_t;
  assign sw.sec_o     = r_disp.sec_o;
  assign sw.cs_t      = r_disp.cs_t;
  assign sw.cs_o      = r_disp.cs_o;
endmodule

// File: tb/tb_stopwatch_core.sv
// Bench for stopwatch_core at TICK_DIV=4: directed scenarios plus random key pulses against a centisecond-count model.
module tb_stopwatch_core;
  localparam int TDIV  = 4;
  localparam int MAXCS = 359999;

  logic clk = 1'b0;
  logic reset = 1'b1;
  stopwatch_core_if sw();

  stopwatch_core #(.TICK_DIV(TDIV), .CNT_W(32)) dut (
    .clk  (clk),
    .reset(reset),
    .sw   (sw)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model: live time as total centiseconds, plus run / lap-frozen / saturated flags.
  int m_cnt = 0, m_pre = 0, m_latch = 0, m_disp = 0;
  bit m_run = 0, m_lap = 0, m_sat = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [23:0] to_bcd(input int c);
    int mm, ss, cc;
    mm = c / 6000;
    ss = (c / 100) % 60;
    cc = c % 100;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), 4'(cc / 10), 4'(cc % 10)};
  endfunction

  function automatic logic [23:0] disp();
    return {sw.min_t, sw.min_o, sw.sec_t, sw.sec_o, sw.cs_t, sw.cs_o};
  endfunction

  function automatic bit bcd_ok(input logic [23:0] d);
    return (d[23:20] <= 4'd5) && (d[19:16] <= 4'd9) && (d[15:12] <= 4'd5) &&
           (d[11:8] <= 4'd9) && (d[7:4] <= 4'd9) && (d[3:0] <= 4'd9);
  endfunction

  task automatic model_edge(input bit rst, input bit ss, input bit cl, input bit lp);
    int nd, pre_cnt;
    bit tick, sat_now;
    if (rst) begin
      m_cnt = 0; m_pre = 0; m_latch = 0; m_disp = 0;
      m_run = 0; m_lap = 0; m_sat = 0;
      return;
    end
    nd      = m_lap ? m_latch : m_cnt;
    pre_cnt = m_cnt;
    sat_now = 1'b0;
    tick    = m_run && (m_pre == TDIV - 1);
    if (m_run) m_pre = tick ? 0 : m_pre + 1;
    if (tick) begin
      if (m_cnt == MAXCS) begin
`ifdef STOPWATCH_SAT_EN
        sat_now = 1'b1;
`else
        m_cnt = 0;
`endif
      end else begin
        m_cnt++;
      end
    end
    if (cl) begin
      if (m_lap) m_lap = 0;
      else if (!m_run) begin
        m_cnt = 0; m_pre = 0; m_latch = 0; m_sat = 0;
      end
    end else if (ss) begin
      if (m_run) begin
        m_run = 0; m_lap = 0;
      end else if (!m_sat) begin
        m_run = 1;
      end
    end else if (lp) begin
      if (m_run) begin
        m_lap = 1; m_latch = pre_cnt;
      end
    end
    if (sat_now) begin
      m_run = 0; m_lap = 0; m_sat = 1;
    end
    m_disp = nd;
  endtask

  task automatic check_outputs();
    check_eq("digits", disp(), to_bcd(m_disp));
    check_eq("running", sw.running, m_run);
    check_eq("lap_shown", sw.lap_shown, m_lap);
    check_eq("bcd_valid", bcd_ok(disp()), 1);
  endtask

  task automatic step(input bit rst, input bit ss, input bit cl, input bit lp);
    reset = rst; sw.start_stop_p = ss; sw.clear_p = cl; sw.lap_p = lp;
    @(posedge clk);
    model_edge(rst, ss, cl, lp);
    #1;
    reset = 0; sw.start_stop_p = 0; sw.clear_p = 0; sw.lap_p = 0;
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0);
  endtask

  task automatic run_to(input int target, input int limit, input string tag);
    bit hit;
    hit = 0;
    for (int i = 0; i < limit && !hit; i++) begin
      if (m_cnt == target) hit = 1;
      else step(0, 0, 0, 0);
    end
    if (m_cnt == target) hit = 1;
    check_eq({tag, "_reached"}, hit, 1);
  endtask

  task automatic wait_tick_edge(input string tag);
    bit hit;
    hit = 0;
    for (int i = 0; i < 2 * TDIV && !hit; i++) begin
      if (m_run && m_pre == TDIV - 1) hit = 1;
      else step(0, 0, 0, 0);
    end
    if (m_run && m_pre == TDIV - 1) hit = 1;
    check_eq({tag, "_reached"}, hit, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    bit hit;
    sw.start_stop_p = 0; sw.clear_p = 0; sw.lap_p = 0;

    // Reset state.
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check_eq("reset_digits", disp(), 24'h000000);
    check_eq("reset_running", sw.running, 0);

    // Reset in the middle of a run at 00:01.23.
    step(0, 1, 0, 0);
    run_to(123, 700, "to_123");
    step(1, 0, 0, 0);
    check_eq("midrun_rst_digits", disp(), 24'h000000);
    check_eq("midrun_rst_running", sw.running, 0);
    idle(20);
    check_eq("idle_no_advance", disp(), 24'h000000);

    // One second of running, then pause holds the display.
    step(0, 1, 0, 0);
    idle(401);
    check_eq("run_1s_digits", disp(), 24'h000100);
    check_eq("run_1s_running", sw.running, 1);
    step(0, 1, 0, 0);
    idle(40);
    check_eq("pause_hold_digits", disp(), 24'h000100);
    check_eq("pause_hold_running", sw.running, 0);

    // Lap freeze at 00:00.57, release with clear at 00:00.80.
    step(0, 0, 1, 0);
    step(0, 1, 0, 0);
    run_to(57, 400, "to_57");
    step(0, 0, 0, 1);
    idle(5);
    check_eq("lap_frozen", disp(), 24'h000057);
    check_eq("lap_shown_hi", sw.lap_shown, 1);
    run_to(80, 300, "to_80");
    step(0, 0, 1, 0);
    check_eq("lap_release", sw.lap_shown, 0);
    step(0, 0, 0, 0);
    check_eq("clear_shows_live", disp(), 24'h000080);

    // PAUSE at 00:02.15 with clear and start_stop together: clear wins.
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    step(0, 1, 0, 0);
    run_to(215, 1000, "to_215");
    step(0, 1, 0, 0);
    step(0, 1, 1, 0);
    idle(2);
    check_eq("clr_wins_digits", disp(), 24'h000000);
    check_eq("clr_wins_running", sw.running, 0);

    // Tick coinciding with start_stop: counted, then pause.
    step(0, 1, 0, 0);
    idle(3);
    wait_tick_edge("tick_ss");
    c0 = m_cnt;
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    check_eq("tick_ss_digits", disp(), to_bcd(c0 + 1));
    check_eq("tick_ss_running", sw.running, 0);

    // Tick coinciding with lap: latch keeps the pre-increment value.
    step(0, 1, 0, 0);
    wait_tick_edge("tick_lap");
    c0 = m_cnt;
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    check_eq("tick_lap_latch", disp(), to_bcd(c0));
    check_eq("tick_lap_shown", sw.lap_shown, 1);
    step(0, 0, 1, 0);
    step(0, 1, 0, 0);

    // Preload 59:59.98 while paused, then run across the top of the range.
    force dut.u_min_t.r_digit = 4'd5;
    force dut.u_min_o.r_digit = 4'd9;
    force dut.u_sec_t.r_digit = 4'd5;
    force dut.u_sec_o.r_digit = 4'd9;
    force dut.u_cs_t.r_digit  = 4'd9;
    force dut.u_cs_o.r_digit  = 4'd8;
    m_cnt = 359998;
    step(0, 0, 0, 0);
    release dut.u_min_t.r_digit;
    release dut.u_min_o.r_digit;
    release dut.u_sec_t.r_digit;
    release dut.u_sec_o.r_digit;
    release dut.u_cs_t.r_digit;
    release dut.u_cs_o.r_digit;
    step(0, 0, 0, 0);
    check_eq("preload", disp(), 24'h595998);
    step(0, 1, 0, 0);
`ifdef STOPWATCH_SAT_EN
    hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      if (!m_run) hit = 1;
      else step(0, 0, 0, 0);
    end
    if (!m_run) hit = 1;
    check_eq("sat_reached", hit, 1);
    step(0, 0, 0, 0);
    check_eq("sat_hold_digits", disp(), 24'h595999);
    check_eq("sat_hold_running", sw.running, 0);
    step(0, 1, 0, 0);
    idle(8);
    check_eq("sat_ss_ignored_run", sw.running, 0);
    check_eq("sat_ss_ignored_dig", disp(), 24'h595999);
    step(0, 0, 1, 0);
    step(0, 0, 0, 0);
    check_eq("sat_clear", disp(), 24'h000000);
`else
    idle(3);
    run_to(0, 20, "wrap");
    step(0, 0, 0, 0);
    check_eq("wrap_digits", disp(), 24'h000000);
    check_eq("wrap_running", sw.running, 1);
`endif

    // Held start_stop key: auto-repeat every 5 cycles toggles RUN/PAUSE.
    step(1, 0, 0, 0);
    for (int k = 0; k < 10; k++) begin
      step(0, 1, 0, 0);
      check_eq("held_toggle", sw.running, (k % 2 == 0));
      idle(4);
    end

    // Random key pulses, occasional reset.
    for (int i = 0; i < 4000; i++) begin
      step($urandom_range(0, 599) == 0, $urandom_range(0, 11) == 0,
           $urandom_range(0, 39) == 0, $urandom_range(0, 14) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/stopwatch_core.md
Name: stopwatch_core

Overview:
- Consumes the one-cycle `pressed` pulses from the key debouncers.
- Runs the stopwatch state machine and a BCD time counter, mm:ss.cc (minutes, seconds, centiseconds).
- Sits directly downstream of the debouncers and upstream of the seven-segment display driver.
- Outputs six registered BCD digits, either the live time or a frozen lap time.

Parameters:
- TICK_DIV, 1000000: clk cycles per centisecond tick (100 MHz clock → 10 ms).
- CNT_W, 32: width of the prescaler counter; must hold TICK_DIV-1.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start_stop_p  input  1  debounced start/stop key pulse; single-cycle; repeats while key held
- clear_p  input  1  debounced clear key pulse
- lap_p  input  1  debounced lap key pulse
- running  output  1  high while time is advancing (RUN or LAP)
- lap_shown  output  1  high while the display shows the frozen lap value
- min_t  output  4  minutes tens digit (0-5)
- min_o  output  4  minutes ones digit (0-9)
- sec_t  output  4  seconds tens digit (0-5)
- sec_o  output  4  seconds ones digit (0-9)
- cs_t  output  4  centiseconds tens digit (0-9)
- cs_o  output  4  centiseconds ones digit (0-9)

Behaviour:
- All state is updated on posedge clk.
- Reset: takes priority over everything and takes effect at the next edge, including mid-run.
  - State goes to IDLE; prescaler, live counter and lap latch go to 0.
  - All digit outputs are 0; running and lap_shown are 0.
- Commands: each input pulse is one command; an auto-repeat pulse is a fresh command.
  - Priority when pulses coincide: clear_p > start_stop_p > lap_p. Lower-priority pulses in the same cycle are dropped.
  - Latency: a command sampled at edge N is visible on the outputs after edge N.
- FSM transitions:
  - IDLE: start_stop → RUN. clear → IDLE (no-op). lap → ignored.
  - RUN: start_stop → PAUSE. lap → copy the live value into the lap latch, go to LAP. clear → ignored.
  - LAP (counter keeps running, display frozen): lap → recapture the latch, stay in LAP. start_stop → PAUSE. clear → RUN (release the display; counter untouched).
  - PAUSE: start_stop → RUN. clear → IDLE (zero the counter, prescaler and latch). lap → ignored.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN and LAP.
  - tick = (prescaler == TICK_DIV-1); on tick the prescaler wraps to 0.
  - Frozen in PAUSE, so a resumed run completes its partial tick; zeroed in IDLE.
- Counter:
  - On tick, the centisecond ones digit increments, and carries ripple in the same cycle: cs_o 9→0 carries to cs_t; cs_t 9→0 to sec_o; sec_o 9→0 to sec_t; sec_t 5→0 to min_o; min_o 9→0 to min_t.
  - min_t 5→0 wraps the whole count 59:59.99 → 00:00.00, and counting continues.
- Display:
  - Outputs show the lap latch when in LAP, otherwise the live counter.
  - Outputs are registered, one cycle after the selected source changes.
  - lap_shown = (state == LAP).
- Boundaries:
  - A tick and a start_stop in the same cycle: the tick is counted, then the FSM goes to PAUSE.
  - A tick and a lap capture in the same cycle: the latch takes the pre-increment value.

Optional Feature:
- Macro: STOPWATCH_SAT_EN.
- Defined: at 59:59.99, a tick does not wrap.
  - The counter holds 59:59.99, the FSM is forced to PAUSE, and running drops.
  - From PAUSE, only clear → IDLE leaves saturation. A start_stop while saturated is ignored.
- Undefined: the count wraps to 00:00.00 as described under Behaviour.

Decomposition:
- Package stopwatch_pkg:
  - FSM state encoding: IDLE=2'd0, RUN=2'd1, PAUSE=2'd2, LAP=2'd3.
  - Digit limit constants: DEC_MAX=4'd9, SEX_MAX=4'd5.
  - BCD time struct/typedef: six 4-bit digits.
- Sub-module bcd_digit:
  - Ports: clk, reset, clr, inc, limit; outputs digit and carry.
  - carry is combinational: inc && digit == limit.
  - Instantiate six times, chained through inc/carry.

Test Plan (run with TICK_DIV=4):
- Reset mid-RUN at count 00:01.23 → next cycle: all digits 0, running=0, state IDLE; a later tick does not advance the count.
- start_stop pulse, then 400 cycles → 00:01.00 shown, running=1. A second start_stop then 40 cycles → display holds 00:01.00.
- Run to 00:00.57, lap pulse → display frozen at 00:00.57 with lap_shown=1 while the counter advances. Clear pulse at live 00:00.80 → display 00:00.80 within 1 cycle, lap_shown=0.
- In PAUSE at 00:02.15, clear_p and start_stop_p in the same cycle → IDLE, digits 00:00.00, running=0 (clear wins).
- Preload/run to 59:59.99, one more tick:
  - Macro off → 00:00.00, running=1.
  - STOPWATCH_SAT_EN → holds 59:59.99, running=0; a later start_stop is ignored; clear → 00:00.00.
- Start_stop pulses repeating every 5 cycles (key held) → state alternates RUN/PAUSE on each pulse; digits remain valid BCD at all times.
